// File: rtl/memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// memory_arbiter_if
//   Bundles the cache-side and RAM-side signals of the memory arbiter.
//
//   Cache side : iREN/iaddr (instruction read), dREN/dWEN/daddr/dstore (data),
//                iwait/dwait (active-low completion), iload/dload (read data)
//   RAM side   : ramREN/ramWEN/ramaddr/ramstore (request), ramload/ramstate
//                (response, FREE=0 BUSY=1 ACCESS=2 ERROR=3)
//   Status     : ram_err, err_timeout (sticky flags)
//
//   slave  : the arbiter's view
//   master : the caches + RAM environment's view
// ---------------------------------------------------------------------------
interface memory_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        iwait;
    logic        dwait;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        ram_err;
    logic        err_timeout;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               ram_err, err_timeout
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               ram_err, err_timeout
    );
endinterface

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//   Arbitrates word requests from the instruction and data caches onto a
//   single-port RAM. One access at a time; the granted cache's wait drops
//   for exactly one cycle when its word completes.
//
//   Ports:
//     CLK  - clock, all state changes on the rising edge
//     RST  - synchronous active-high reset
//     bus  - memory_arbiter_if.slave (cache requests/responses, RAM port,
//            sticky ram_err / err_timeout flags)
//
//   Parameters:
//     STARVE_MAX     - data grants in a row allowed while iREN waits
//     TIMEOUT_CYCLES - watchdog length in access-state cycles
//
//   Optional feature macro: MEMCTRL_TIMEOUT_EN
//     Defined  : watchdog forces a completion (load = 32'hBAD1BAD1) after
//                TIMEOUT_CYCLES access cycles and sets err_timeout.
//     Undefined: accesses wait indefinitely; err_timeout is tied low.
// ---------------------------------------------------------------------------
module memory_arbiter #(
    parameter int STARVE_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            CLK,
    input  logic            RST,
    memory_arbiter_if.slave bus
);
    localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    state_t              state;
    logic [STARVE_W-1:0] starveCnt;
    logic [31:0]         reqAddr;
    logic [31:0]         reqStore;
    logic                renReg;
    logic                wenReg;
    logic                ramErrReg;

    logic                dataReq;
    logic                grantedEn;
    logic                ramDone;
    logic                timeoutHit;
    logic                complete;
    logic                abortAcc;
    logic [1:0]          chanDone;   // [0] data, [1] instruction

    assign dataReq = bus.dREN | bus.dWEN;
    assign ramDone = (bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR);

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmoCnt;
    logic             errTimeoutReg;

    // tmoCnt is 0 in the first access cycle, so the hit lands in access
    // cycle number TIMEOUT_CYCLES.
    assign timeoutHit = (state != IDLE) && !ramDone &&
                        (tmoCnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign bus.err_timeout = errTimeoutReg;
    assign bus.iload = timeoutHit ? 32'hBAD1BAD1 : bus.ramload;
    assign bus.dload = timeoutHit ? 32'hBAD1BAD1 : bus.ramload;
`else
    localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;
    assign timeoutHit      = 1'b0;
    assign bus.err_timeout = 1'b0;
    assign bus.iload       = bus.ramload;
    assign bus.dload       = bus.ramload;
`endif

    // Enable of the cache currently being served; it dropping means abort.
    always_comb begin
        grantedEn = 1'b0;
        case (state)
            DACC:    grantedEn = dataReq;
            IACC:    grantedEn = bus.iREN;
            default: grantedEn = 1'b0;
        endcase
    end

    // A cache that has already withdrawn gets no completion, even if the RAM
    // answers in the same cycle.
    assign complete = grantedEn && (ramDone || timeoutHit);
    assign abortAcc = (state != IDLE) && !grantedEn;

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        localparam state_t CH_STATE = (gi == 0) ? DACC : IACC;
        assign chanDone[gi] = complete && (state == CH_STATE);
    end

    assign bus.dwait    = ~chanDone[0];
    assign bus.iwait    = ~chanDone[1];
    assign bus.ramREN   = renReg;
    assign bus.ramWEN   = wenReg;
    assign bus.ramaddr  = reqAddr;
    assign bus.ramstore = reqStore;
    assign bus.ram_err  = ramErrReg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            starveCnt <= '0;
            reqAddr   <= '0;
            reqStore  <= '0;
            renReg    <= 1'b0;
            wenReg    <= 1'b0;
            ramErrReg <= 1'b0;
`ifdef MEMCTRL_TIMEOUT_EN
            tmoCnt        <= '0;
            errTimeoutReg <= 1'b0;
`endif
        end else begin
`ifdef MEMCTRL_TIMEOUT_EN
            // Every access is entered from IDLE, so clearing here restarts
            // the watchdog on each grant.
            tmoCnt <= (state == IDLE) ? '0 : tmoCnt + 1'b1;
            if (complete && timeoutHit)
                errTimeoutReg <= 1'b1;
`endif
            if (complete && (bus.ramstate == RAM_ERROR))
                ramErrReg <= 1'b1;

            if (complete) begin
                if ((state == IACC) || !bus.iREN)
                    starveCnt <= '0;
                else if (starveCnt != STARVE_LIMIT)
                    starveCnt <= starveCnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.iREN && (!dataReq || (starveCnt == STARVE_LIMIT))) begin
                        state    <= IACC;
                        reqAddr  <= bus.iaddr;
                        reqStore <= '0;
                        renReg   <= 1'b1;
                        wenReg   <= 1'b0;
                    end else if (dataReq) begin
                        state    <= DACC;
                        reqAddr  <= bus.daddr;
                        reqStore <= bus.dstore;
                        renReg   <= ~bus.dWEN;
                        wenReg   <= bus.dWEN;
                    end
                end
                default: begin
                    if (complete || abortAcc) begin
                        state  <= IDLE;
                        renReg <= 1'b0;
                        wenReg <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
//   Self-checking bench for memory_arbiter. A RAM responder answers with a
//   programmable number of BUSY cycles; requests push expected completions
//   into per-cache queues, and a monitor pops them when a wait drops.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;
    localparam logic [1:0] R_FREE   = 2'd0;
    localparam logic [1:0] R_BUSY   = 2'd1;
    localparam logic [1:0] R_ACCESS = 2'd2;
    localparam logic [1:0] R_ERROR  = 2'd3;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] store;
        logic        wr;
        logic [31:0] load;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;

    memory_arbiter_if bus();

    memory_arbiter #(
        .STARVE_MAX     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    exp_t        iQ[$];
    exp_t        dQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] refMem[0:255];
    logic [31:0] ramMem[0:255];
    int          busyCycles = 0;
    bit          holdBusy   = 1'b0;
    bit          forceErr   = 1'b0;
    int          cycleCnt   = 0;
    int          doneCycles[$];
    string       orderLog;

    always @(posedge CLK) cycleCnt <= cycleCnt + 1;

    // RAM responder: BUSY for busyCycles cycles of an access, then ACCESS
    initial begin : responder
        int busyCnt;
        busyCnt      = 0;
        bus.ramstate = R_FREE;
        bus.ramload  = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.ramREN || bus.ramWEN) begin
                if (holdBusy || (busyCnt < busyCycles)) begin
                    bus.ramstate = R_BUSY;
                    bus.ramload  = '0;
                    busyCnt++;
                end else begin
                    bus.ramstate = forceErr ? R_ERROR : R_ACCESS;
                    bus.ramload  = ramMem[bus.ramaddr[7:0]];
                    if (bus.ramWEN) ramMem[bus.ramaddr[7:0]] = bus.ramstore;
                end
            end else begin
                bus.ramstate = R_FREE;
                busyCnt      = 0;
            end
        end
    end

    // Scoreboard monitor: one line per completed transaction
    initial begin : monitor
        exp_t monE;
        forever begin
            @(negedge CLK);
            if (!bus.iwait && !bus.dwait) begin
                checks++; errors++;
                $display("FAIL both_waits_low iwait=%b dwait=%b required one high", bus.iwait, bus.dwait);
            end
            if (bus.dwait === 1'b0) begin
                checks++;
                if (dQ.size() == 0) begin
                    errors++;
                    $display("FAIL dwait_unexpected ramaddr=%h required no data completion", bus.ramaddr);
                end else begin
                    monE = dQ.pop_front();
                    if (bus.ramaddr !== monE.addr || bus.ramWEN !== monE.wr || bus.ramREN !== !monE.wr ||
                        (monE.wr && bus.ramstore !== monE.store) || (!monE.wr && bus.dload !== monE.load)) begin
                        errors++;
                        $display("FAIL data_txn got addr=%h wen=%b ren=%b store=%h load=%h required addr=%h wr=%b store=%h load=%h",
                                 bus.ramaddr, bus.ramWEN, bus.ramREN, bus.ramstore, bus.dload,
                                 monE.addr, monE.wr, monE.store, monE.load);
                    end else begin
                        $display("data  txn addr=%h wr=%b store=%h load=%h ok", monE.addr, monE.wr, monE.store, bus.dload);
                    end
                end
            end
            if (bus.iwait === 1'b0) begin
                checks++;
                if (iQ.size() == 0) begin
                    errors++;
                    $display("FAIL iwait_unexpected ramaddr=%h required no instr completion", bus.ramaddr);
                end else begin
                    monE = iQ.pop_front();
                    if (bus.ramaddr !== monE.addr || bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 ||
                        bus.iload !== monE.load) begin
                        errors++;
                        $display("FAIL instr_txn got addr=%h ren=%b wen=%b load=%h required addr=%h ren=1 wen=0 load=%h",
                                 bus.ramaddr, bus.ramREN, bus.ramWEN, bus.iload, monE.addr, monE.load);
                    end else begin
                        $display("instr txn addr=%h load=%h ok", monE.addr, bus.iload);
                    end
                end
            end
        end
    end

    // Data cache driver: n consecutive words, next word presented right
    // after the previous completes; enables dropped after the last.
    task automatic dataOps(input int n, input logic [31:0] base, input logic wr,
                           input logic [31:0] storeBase);
        exp_t e;
        bit   seen;
        for (int k = 0; k < n; k++) begin
            e.addr  = base + 32'(k);
            e.store = storeBase + 32'(k);
            e.wr    = wr;
            e.load  = refMem[e.addr[7:0]];
            if (wr) refMem[e.addr[7:0]] = e.store;
            dQ.push_back(e);
            bus.daddr  = e.addr;
            bus.dstore = e.store;
            bus.dWEN   = wr;
            bus.dREN   = ~wr;
            seen = 1'b0;
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge CLK);
                if (bus.dwait === 1'b0) seen = 1'b1;
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL dwait_wait addr=%h got no completion in 200 cycles required one", e.addr);
            end else begin
                orderLog = {orderLog, "D"};
                doneCycles.push_back(cycleCnt);
            end
            @(posedge CLK);
            #1;
        end
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
    endtask

    task automatic instrOps(input int n, input logic [31:0] base);
        exp_t e;
        bit   seen;
        for (int k = 0; k < n; k++) begin
            e.addr  = base + 32'(k);
            e.store = '0;
            e.wr    = 1'b0;
            e.load  = refMem[e.addr[7:0]];
            iQ.push_back(e);
            bus.iaddr = e.addr;
            bus.iREN  = 1'b1;
            seen = 1'b0;
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge CLK);
                if (bus.iwait === 1'b0) seen = 1'b1;
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL iwait_wait addr=%h got no completion in 200 cycles required one", e.addr);
            end else begin
                orderLog = {orderLog, "I"};
                doneCycles.push_back(cycleCnt);
            end
            @(posedge CLK);
            #1;
        end
        bus.iREN = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 ||
            bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0 || bus.ram_err !== 1'b0 || bus.err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset got iwait=%b dwait=%b ren=%b wen=%b addr=%h store=%h err=%b tmo=%b required 1 1 0 0 0 0 0 0",
                     bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.ram_err, bus.err_timeout);
        end
        $display("reset done");
    endtask

    task automatic test_single_read();
        exp_t e;
        logic expRen, expWait;
        busyCycles = 3;
        e.addr = 32'h40; e.store = '0; e.wr = 1'b0; e.load = 32'h1234;
        dQ.push_back(e);
        @(posedge CLK);
        #1;
        bus.daddr = 32'h40;
        bus.dREN  = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge CLK);
            expRen  = (c >= 1 && c <= 4);
            expWait = (c != 4);
            checks++;
            if (bus.ramREN !== expRen || bus.dwait !== expWait) begin
                errors++;
                $display("FAIL single_read cycle=%0d got ramREN=%b dwait=%b required %b %b", c, bus.ramREN, bus.dwait, expRen, expWait);
            end
            if (c == 4) begin
                checks++;
                if (bus.dload !== 32'h1234) begin
                    errors++;
                    $display("FAIL single_read_load got %h required 00001234", bus.dload);
                end
            end
            @(posedge CLK);
            #1;
            if (c == 4) bus.dREN = 1'b0;
        end
        busyCycles = 0;
    endtask

    task automatic test_simultaneous();
        busyCycles = 1;
        orderLog   = "";
        doneCycles.delete();
        @(posedge CLK);
        #1;
        fork
            dataOps(1, 32'h80, 1'b1, 32'hCAFE);
            instrOps(1, 32'h10);
            begin
                @(negedge CLK);
                @(negedge CLK);
                checks++;
                if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h80 || bus.ramstore !== 32'hCAFE) begin
                    errors++;
                    $display("FAIL simul_grant got wen=%b ren=%b addr=%h store=%h required 1 0 00000080 0000cafe",
                             bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore);
                end
            end
        join
        checks++;
        if (orderLog != "DI") begin
            errors++;
            $display("FAIL simul_order got %s required DI", orderLog);
        end
        checks++;
        if (doneCycles.size() != 2 || (doneCycles[1] - doneCycles[0]) != 3) begin
            errors++;
            $display("FAIL simul_gap got %0d completions required instr done 3 cycles after data", doneCycles.size());
        end
        busyCycles = 0;
    endtask

    task automatic test_back_to_back();
        busyCycles = 0;
        doneCycles.delete();
        @(posedge CLK);
        #1;
        dataOps(4, 32'h60, 1'b1, 32'h5000);
        dataOps(4, 32'h60, 1'b0, 32'h0);
        for (int k = 1; k < 8; k++) begin
            checks++;
            if (doneCycles.size() != 8 || (doneCycles[k] - doneCycles[k-1]) != 2) begin
                errors++;
                $display("FAIL b2b_gap idx=%0d completions=%0d required 8 completions 2 cycles apart", k, doneCycles.size());
            end
        end
    endtask

    task automatic test_starvation();
        busyCycles = 0;
        orderLog   = "";
        @(posedge CLK);
        #1;
        fork
            instrOps(2, 32'h20);
            dataOps(8, 32'hA0, 1'b0, 32'h0);
        join
        checks++;
        if (orderLog != "DDDDIDDDDI") begin
            errors++;
            $display("FAIL starvation_order got %s required DDDDIDDDDI", orderLog);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        holdBusy = 1'b1;
        e.addr = 32'h24; e.store = '0; e.wr = 1'b0; e.load = refMem[8'h24];
        iQ.push_back(e);
        @(posedge CLK);
        #1;
        bus.daddr = 32'h44; bus.dREN = 1'b1;
        bus.iaddr = 32'h24; bus.iREN = 1'b1;
        @(negedge CLK);                      // cycle 0: IDLE
        @(posedge CLK); #1;
        @(negedge CLK);                      // cycle 1: first DACC
        checks++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h44) begin
            errors++;
            $display("FAIL abort_grant got ren=%b addr=%h required 1 00000044", bus.ramREN, bus.ramaddr);
        end
        @(posedge CLK); #1;
        bus.dREN = 1'b0;                     // cycle 2: drop in second DACC
        @(negedge CLK);
        checks++;
        if (bus.dwait !== 1'b1) begin
            errors++;
            $display("FAIL abort_nopulse got dwait=%b required 1", bus.dwait);
        end
        @(posedge CLK); #1;
        holdBusy = 1'b0;
        @(negedge CLK);                      // cycle 3: IDLE
        checks++;
        if (bus.ramREN !== 1'b0 || bus.dwait !== 1'b1 || bus.iwait !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle got ren=%b dwait=%b iwait=%b required 0 1 1", bus.ramREN, bus.dwait, bus.iwait);
        end
        @(posedge CLK); #1;
        @(negedge CLK);                      // cycle 4: IACC completes
        checks++;
        if (bus.iwait !== 1'b0 || bus.ramaddr !== 32'h24) begin
            errors++;
            $display("FAIL abort_then_instr got iwait=%b addr=%h required 0 00000024", bus.iwait, bus.ramaddr);
        end
        @(posedge CLK); #1;
        bus.iREN = 1'b0;
    endtask

    task automatic test_error();
        checks++;
        if (bus.ram_err !== 1'b0) begin
            errors++;
            $display("FAIL err_before got %b required 0", bus.ram_err);
        end
        forceErr = 1'b1;
        dataOps(1, 32'h30, 1'b0, 32'h0);
        forceErr = 1'b0;
        checks++;
        if (bus.ram_err !== 1'b1) begin
            errors++;
            $display("FAIL err_set got %b required 1", bus.ram_err);
        end
        dataOps(1, 32'h31, 1'b0, 32'h0);
        checks++;
        if (bus.ram_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b required 1", bus.ram_err);
        end
    endtask

`ifdef MEMCTRL_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        logic expWait;
        holdBusy = 1'b1;
        e.addr = 32'h50; e.store = '0; e.wr = 1'b0; e.load = 32'hBAD1BAD1;
        dQ.push_back(e);
        @(posedge CLK);
        #1;
        bus.daddr = 32'h50;
        bus.dREN  = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge CLK);
            if (c <= 8) begin
                expWait = (c != 8);
                checks++;
                if (bus.dwait !== expWait) begin
                    errors++;
                    $display("FAIL timeout_wait cycle=%0d got dwait=%b required %b", c, bus.dwait, expWait);
                end
            end
            if (c == 8) begin
                checks++;
                if (bus.dload !== 32'hBAD1BAD1) begin
                    errors++;
                    $display("FAIL timeout_load got %h required bad1bad1", bus.dload);
                end
            end
            if (c == 9) begin
                checks++;
                if (bus.err_timeout !== 1'b1 || bus.ramREN !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_flag got tmo=%b ren=%b required 1 0", bus.err_timeout, bus.ramREN);
                end
            end
            @(posedge CLK);
            #1;
            if (c == 8) bus.dREN = 1'b0;
        end
        holdBusy = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (bus.err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got %b required 1", bus.err_timeout);
        end
    endtask
`endif

    task automatic test_reset_mid();
        holdBusy = 1'b1;
        @(posedge CLK);
        #1;
        bus.iaddr = 32'h28;
        bus.iREN  = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h28) begin
            errors++;
            $display("FAIL rstmid_iacc got ren=%b addr=%h required 1 00000028", bus.ramREN, bus.ramaddr);
        end
        @(posedge CLK); #1;
        RST      = 1'b1;
        bus.iREN = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.iwait !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h0 ||
            bus.ram_err !== 1'b0 || bus.err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rstmid got iwait=%b ren=%b addr=%h err=%b tmo=%b required 1 0 0 0 0",
                     bus.iwait, bus.ramREN, bus.ramaddr, bus.ram_err, bus.err_timeout);
        end
        holdBusy = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            refMem[i] = 32'hA500_0000 | 32'(i);
            ramMem[i] = 32'hA500_0000 | 32'(i);
        end
        refMem[8'h40] = 32'h1234;
        ramMem[8'h40] = 32'h1234;
        bus.iREN   = 1'b0;
        bus.iaddr  = '0;
        bus.dREN   = 1'b0;
        bus.dWEN   = 1'b0;
        bus.daddr  = '0;
        bus.dstore = '0;
        orderLog   = "";

        test_reset();
        test_single_read();
        test_simultaneous();
        test_back_to_back();
        test_starvation();
        test_abort();
        test_error();
`ifdef MEMCTRL_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();

        checks++;
        if (iQ.size() != 0 || dQ.size() != 0) begin
            errors++;
            $display("FAIL leftover got iQ=%0d dQ=%0d pending required 0 0", iQ.size(), dQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

- Clocked responder on the cache/memory protocol.
- Accepts word requests from the instruction cache (iREN) and the data cache (dREN/dWEN) and grants one of them at a time.
- Performs the granted access on the single-port RAM and releases that cache's wait signal for exactly one cycle when the word completes.
- Sits between the per-core caches and RAM, in the slot occupied by the memory controller.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while iREN is pending before the instruction cache is forced a grant.
- TIMEOUT_CYCLES, 64: access-state cycles before watchdog completion. Used only with MEMCTRL_TIMEOUT_EN.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset; synchronous, active-high
- iREN  in  1  instruction read request
- iaddr  in  32  instruction word address
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data word address
- dstore  in  32  data write word
- iwait  out  1  low for exactly one cycle when an instruction access completes
- dwait  out  1  low for exactly one cycle when a data access completes
- iload  out  32  instruction read data
- dload  out  32  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- ram_err  out  1  sticky; set when ramstate==ERROR completes an access
- err_timeout  out  1  sticky watchdog flag

## Operation
States: IDLE, DACC, IACC.

IDLE:
- Sample requests each cycle.
- The data request wins when present. dREN|dWEN is a data request; dWEN wins if both dREN and dWEN are high.
- Exception: starve_cnt==STARVE_MAX and iREN high grants the instruction cache instead.
- On grant, register {addr, store word, write flag} from the winning cache, then go to DACC or IACC.
- No request: stay in IDLE.

DACC/IACC:
- Drive ramREN/ramWEN, ramaddr and ramstore from the registered request.
- Completion occurs when ramstate is ACCESS or ERROR:
  - that cycle, the granted cache's wait is 0 (combinational);
  - return to IDLE;
  - ERROR additionally sets ram_err.
- Abort: if the granted cache drops its enable before completion, return to IDLE next cycle with no completion. RAM enables go low in IDLE.

Starvation counter (starve_cnt, 0..STARVE_MAX):
- +1 on each data completion while iREN is high.
- Cleared on any instruction completion.
- Cleared on any data completion with iREN low.
- Saturates at STARVE_MAX.

Outputs:
- iload = dload = ramload, combinational. Only meaningful in the completion cycle.
- Ungranted cache's wait is held 1. Both waits are 1 in IDLE.

Reset (RST high at an edge):
- state=IDLE, starve_cnt=0, registered request=0, ram_err=0, err_timeout=0.
- Outputs after reset: iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0.
- Reset mid-access drops the access with no completion pulse.

## Timing
- Minimum per-word latency is 2 cycles: request seen in IDLE (cycle 0), RAM driven and completion possible in cycle 1.
- One mandatory IDLE turnaround cycle follows every completion or abort, so back-to-back words cost at least 2 cycles each.
- Requests must hold address and data stable until their wait drops. The arbiter uses only the values registered at grant.
- A request asserted in the same cycle another cache completes is arbitrated in the following IDLE cycle.

## Configuration
MEMCTRL_TIMEOUT_EN:
- Defined: a counter runs in DACC/IACC. After TIMEOUT_CYCLES cycles without completion:
  - force a completion (wait low one cycle);
  - override iload/dload to 32'hBAD1BAD1;
  - set err_timeout;
  - deassert RAM enables and return to IDLE.
  - The counter clears on every state entry.
- Undefined: no counter; accesses wait indefinitely and err_timeout is tied 0.

## Test plan
- Single data read: dREN=1, daddr=0x40, ramstate=ACCESS after 3 BUSY cycles, ramload=0x1234 -> ramREN high in cycles 1-4; dwait=0 only in cycle 4 with dload=0x1234; then IDLE.
- Simultaneous iREN and dWEN (daddr=0x80, dstore=0xCAFE) -> data granted first (ramWEN=1, ramaddr=0x80, ramstore=0xCAFE); instruction granted in the IDLE after.
- Starvation: iREN held high and the data side requesting continuously -> after 4 data completions the 5th grant goes to the instruction cache; starve_cnt returns to 0.
- Abort: dREN dropped in the 2nd DACC cycle while ramstate=BUSY -> no dwait pulse; ramREN=0 the next cycle; iREN pending is granted after.
- Reset mid-IACC: RST high for one edge -> iwait=1, ramREN=0, state IDLE; ram_err and err_timeout cleared.
- With MEMCTRL_TIMEOUT_EN and TIMEOUT_CYCLES=8, ramstate held BUSY -> dwait=0 in the 8th access cycle with dload=0xBAD1BAD1; err_timeout=1 and stays set until reset.
